ots_match_engine: RTL and testbench

//  Search datapath fed by the offTargetSearcher AXI4-Lite register slave: guide, threshold, length, start.

---
 rtl/ots_pkg.sv | 28 ++
 rtl/ots_match_engine_if.sv | 37 +++
 rtl/ots_mm_counter.sv | 22 ++
 rtl/ots_match_engine.sv | 176 +++++++++++++++++
 tb/tb_ots_match_engine.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ots_pkg.sv
// Shared types and constants for the off-target search match engine.
package ots_pkg;

    localparam int GUIDE_LEN_DEF = 20;
    localparam int POS_W_DEF     = 32;
    localparam int PAM_LEN       = 3;
    localparam int HIT_IDX_LSB   = 0;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_SEARCH = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // The mismatch count sits directly above the window start index in a hit word.
    function automatic int hit_mm_lsb(input int pos_w);
        return HIT_IDX_LSB + pos_w;
    endfunction

endpackage

// File: rtl/ots_match_engine_if.sv
// Configuration, base stream, hit stream and status bundle between the register slave and the engine.
interface ots_match_engine_if #(
    parameter int GUIDE_LEN = 20,
    parameter int POS_W     = 32,
    parameter int MM_W      = $clog2(GUIDE_LEN + 1)
);
    logic [2*GUIDE_LEN-1:0] cfg_guide;
    logic [MM_W-1:0]        cfg_max_mm;
    logic [POS_W-1:0]       cfg_length;
    logic                   cfg_start;

    logic [1:0]             s_base_tdata;
    logic                   s_base_tvalid;
    logic                   s_base_tready;

    logic [POS_W+MM_W-1:0]  m_hit_tdata;
    logic                   m_hit_tvalid;
    logic                   m_hit_tready;

    logic                   busy;
    logic                   done;
    logic [POS_W-1:0]       hit_count;

    modport master (
        output cfg_guide, cfg_max_mm, cfg_length, cfg_start,
        output s_base_tdata, s_base_tvalid, m_hit_tready,
        input  s_base_tready, m_hit_tdata, m_hit_tvalid,
        input  busy, done, hit_count
    );

    modport slave (
        input  cfg_guide, cfg_max_mm, cfg_length, cfg_start,
        input  s_base_tdata, s_base_tvalid, m_hit_tready,
        output s_base_tready, m_hit_tdata, m_hit_tvalid,
        output busy, done, hit_count
    );
endinterface

// File: rtl/ots_mm_counter.sv
// Combinational mismatch counter: number of 2-bit base positions where guide and window differ.
module ots_mm_counter
    import ots_pkg::*;
#(
    parameter int GUIDE_LEN = GUIDE_LEN_DEF,
    parameter int MM_W      = $clog2(GUIDE_LEN + 1)
) (
    input  logic [2*GUIDE_LEN-1:0] guide_i,
    input  logic [2*GUIDE_LEN-1:0] win_i,
    output logic [MM_W-1:0]        mm_o
);

    always_comb begin
        mm_o = '0;
        for (int k = 0; k < GUIDE_LEN; k++) begin
            if (|(guide_i[2*k +: 2] ^ win_i[2*k +: 2])) begin
                mm_o = mm_o + MM_W'(1);
            end
        end
    end

endmodule

// File: rtl/ots_match_engine.sv
// Sliding-window guide matcher with a two-stage compare pipeline and valid/ready hit output.
// Define OTS_PAM_CHECK_EN to extend the window by a PAM and require NGG after the guide.
module ots_match_engine
    import ots_pkg::*;
#(
    parameter int GUIDE_LEN = GUIDE_LEN_DEF,
    parameter int POS_W     = POS_W_DEF,
    parameter int MM_W      = $clog2(GUIDE_LEN + 1)
) (
    input  logic         clock,
    input  logic         reset,
    ots_match_engine_if.slave bus
);

`ifdef OTS_PAM_CHECK_EN
    localparam int WIN = GUIDE_LEN + PAM_LEN;
`else
    localparam int WIN = GUIDE_LEN;
`endif
    localparam logic [POS_W-1:0] WIN_M1     = POS_W'(WIN - 1);
    localparam int               HIT_MM_LSB = hit_mm_lsb(POS_W);

    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        return (&v) ? v : v + POS_W'(1);
    endfunction

    state_t                  state_q, state_d;
    logic [2*GUIDE_LEN-1:0]  guide_q;
    logic [MM_W-1:0]         max_mm_q;
    logic [POS_W-1:0]        len_q;
    logic [POS_W-1:0]        idx_q;
    logic [2*WIN-1:0]        win_q, win_d;
    logic                    done_q;
    logic [POS_W-1:0]        hit_cnt_q;

    logic                    vld_p1_q;
    logic [2*WIN-1:0]        win_p1_q;
    logic [POS_W-1:0]        pos_p1_q;
    logic                    vld_p2_q;
    logic [POS_W+MM_W-1:0]   hit_data_q, hit_data_d;

    logic                    adv, st1_free, base_rdy, accept, in_win, last_base;
    logic                    start_go, fin;
    logic [MM_W-1:0]         mm_p1;
    logic                    pam_ok, hit_p1;

    // Output register drains when empty or consumed; stage 1 moves whenever stage 2 can take it.
    assign adv       = !vld_p2_q || bus.m_hit_tready;
    assign st1_free  = !vld_p1_q || adv;
    assign base_rdy  = ((state_q == S_FILL) || (state_q == S_SEARCH)) && st1_free;
    assign accept    = base_rdy && bus.s_base_tvalid;
    assign in_win    = idx_q >= WIN_M1;
    assign last_base = idx_q == (len_q - POS_W'(1));
    assign win_d     = {bus.s_base_tdata, win_q[2*WIN-1:2]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        fin      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    start_go = 1'b1;
                    state_d  = (bus.cfg_length == '0) ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (last_base) begin
                        state_d = S_DRAIN;
                    end else if (idx_q == WIN_M1) begin
                        state_d = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if (accept && last_base) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) begin
                    state_d = S_IDLE;
                    fin     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    ots_mm_counter #(
        .GUIDE_LEN (GUIDE_LEN),
        .MM_W      (MM_W)
    ) u_mm (
        .guide_i (guide_q),
        .win_i   (win_p1_q[2*GUIDE_LEN-1:0]),
        .mm_o    (mm_p1)
    );

`ifdef OTS_PAM_CHECK_EN
    assign pam_ok = (win_p1_q[2*WIN-1 -: 2] == BASE_G) && (win_p1_q[2*WIN-3 -: 2] == BASE_G);
`else
    assign pam_ok = 1'b1;
`endif
    assign hit_p1 = (mm_p1 <= max_mm_q) && pam_ok;

    always_comb begin
        hit_data_d = '0;
        hit_data_d[HIT_IDX_LSB +: POS_W] = pos_p1_q;
        hit_data_d[HIT_MM_LSB +: MM_W]   = mm_p1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            guide_q    <= '0;
            max_mm_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            win_q      <= '0;
            done_q     <= 1'b0;
            hit_cnt_q  <= '0;
            vld_p1_q   <= 1'b0;
            win_p1_q   <= '0;
            pos_p1_q   <= '0;
            vld_p2_q   <= 1'b0;
            hit_data_q <= '0;
        end else begin
            if (start_go) begin
                guide_q   <= bus.cfg_guide;
                max_mm_q  <= bus.cfg_max_mm;
                len_q     <= bus.cfg_length;
                idx_q     <= '0;
                win_q     <= '0;
                done_q    <= 1'b0;
                hit_cnt_q <= '0;
            end
            if (accept) begin
                win_q <= win_d;
                idx_q <= idx_q + POS_W'(1);
            end
            // Stage 1: capture the full window ending at the accepted base.
            if (st1_free) begin
                vld_p1_q <= accept && in_win;
                win_p1_q <= win_d;
                pos_p1_q <= idx_q - WIN_M1;
            end
            // Stage 2: only qualifying windows become visible on the hit stream.
            if (adv) begin
                vld_p2_q   <= vld_p1_q && hit_p1;
                hit_data_q <= hit_data_d;
            end
            if (vld_p2_q && bus.m_hit_tready) begin
                hit_cnt_q <= sat_inc(hit_cnt_q);
            end
            if (fin) begin
                done_q <= 1'b1;
            end
        end
    end

    assign bus.s_base_tready = base_rdy;
    assign bus.m_hit_tvalid  = vld_p2_q;
    assign bus.m_hit_tdata   = hit_data_q;
    assign bus.busy          = state_q != S_IDLE;
    assign bus.done          = done_q;
    assign bus.hit_count     = hit_cnt_q;

endmodule

// File: tb/tb_ots_match_engine.sv
// Bench for ots_match_engine: directed searches plus randomized streams against a window-scan model.
module tb_ots_match_engine;
    import ots_pkg::*;

    localparam int GL = 20;
    localparam int PW = 32;
    localparam int MW = $clog2(GL + 1);
`ifdef OTS_PAM_CHECK_EN
    localparam int WIN = GL + 3;
`else
    localparam int WIN = GL;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ots_match_engine_if #(.GUIDE_LEN(GL), .POS_W(PW), .MM_W(MW)) bus ();

    ots_match_engine #(.GUIDE_LEN(GL), .POS_W(PW), .MM_W(MW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]        seq[$];
    logic [PW+MW-1:0]  exp_q[$];
    logic [PW+MW-1:0]  got_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scan every complete window of the stream and keep the qualifying ones.
    function automatic void model(input logic [2*GL-1:0] g, input int max_mm, input int len);
        exp_q.delete();
        for (int s = 0; s + WIN <= len; s++) begin
            int mm;
            bit pam;
            mm = 0;
            for (int k = 0; k < GL; k++) begin
                if (seq[s+k] != g[2*k +: 2]) mm++;
            end
            pam = 1'b1;
`ifdef OTS_PAM_CHECK_EN
            pam = (seq[s+WIN-2] == 2'd2) && (seq[s+WIN-1] == 2'd2);
`endif
            if (mm <= max_mm && pam) exp_q.push_back({MW'(mm), PW'(s)});
        end
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " busy"},    bus.busy, 0);
        check({tag, " done"},    bus.done, 0);
        check({tag, " hitcnt"},  bus.hit_count, 0);
        check({tag, " hvalid"},  bus.m_hit_tvalid, 0);
        check({tag, " hdata"},   bus.m_hit_tdata, 0);
        check({tag, " bready"},  bus.s_base_tready, 0);
    endtask

    // rmode: 0 always ready, 1 ready one cycle in four, 2 random.
    task automatic run(input string tag, input logic [2*GL-1:0] g, input int max_mm, input int len,
                       input int rmode, input bit gaps, input int pulse_cyc, input int abort_at,
                       input bit want_rdy_low);
        int bi, cyc, low_rdy;
        bit finished, prev_stall;
        logic [PW+MW-1:0] prev_data;
        model(g, max_mm, len);
        got_q.delete();
        bi = 0; low_rdy = 0; finished = 1'b0; prev_stall = 1'b0; prev_data = '0;
        @(negedge clock);
        bus.cfg_guide  = g;
        bus.cfg_max_mm = MW'(max_mm);
        bus.cfg_length = PW'(len);
        bus.cfg_start  = 1'b1;
        @(negedge clock);
        bus.cfg_start = 1'b0;
        check({tag, " busy after start"}, bus.busy, 1);
        check({tag, " done cleared"}, bus.done, 0);
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (bus.done) begin
                finished = 1'b1;
                break;
            end
            case (rmode)
                0:       bus.m_hit_tready = 1'b1;
                1:       bus.m_hit_tready = (cyc % 4) == 3;
                default: bus.m_hit_tready = 1'($urandom_range(0, 1));
            endcase
            bus.cfg_start = (cyc == pulse_cyc);
            if (cyc == pulse_cyc) bus.cfg_length = PW'(3);
            bus.s_base_tvalid = (bi < len) && (!gaps || ($urandom_range(0, 3) != 0));
            bus.s_base_tdata  = bus.s_base_tvalid ? seq[bi] : 2'($urandom_range(0, 3));
            #1;
            if (prev_stall) check({tag, " stall hold"}, {bus.m_hit_tvalid, bus.m_hit_tdata}, {1'b1, prev_data});
            prev_stall = bus.m_hit_tvalid && !bus.m_hit_tready;
            prev_data  = bus.m_hit_tdata;
            if (bi < len && !bus.s_base_tready) low_rdy++;
            if (bus.s_base_tvalid && bus.s_base_tready) bi++;
            if (bus.m_hit_tvalid && bus.m_hit_tready) got_q.push_back(bus.m_hit_tdata);
            if (abort_at >= 0 && bi == abort_at) begin
                @(negedge clock);
                bus.s_base_tvalid = 1'b0;
                bus.cfg_start = 1'b0;
                return;
            end
        end
        bus.s_base_tvalid = 1'b0;
        bus.cfg_start = 1'b0;
        check({tag, " finished in budget"}, finished, 1);
        check({tag, " done"}, bus.done, 1);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " hit total"}, got_q.size(), exp_q.size());
        check({tag, " hit_count"}, bus.hit_count, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, " hit word"}, got_q[i], exp_q[i]);
        if (want_rdy_low) check({tag, " base ready dropped"}, low_rdy > 0, 1);
    endtask

    task automatic check_t1_const(input string tag);
`ifndef OTS_PAM_CHECK_EN
        check({tag, " const n"}, got_q.size(), 6);
        check({tag, " const hit_count"}, bus.hit_count, 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check({tag, " const word"}, got_q[i], {MW'(0), PW'(i)});
`else
        check({tag, " pam no hit"}, got_q.size(), 0);
`endif
    endtask

    initial begin
        logic [2*GL-1:0] g_acgt, g_rand;
        int len, mm;
        reset = 1'b1;
        bus.cfg_guide = '0; bus.cfg_max_mm = '0; bus.cfg_length = '0; bus.cfg_start = 1'b0;
        bus.s_base_tdata = '0; bus.s_base_tvalid = 1'b0; bus.m_hit_tready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b0;

        // All-A guide over 25 A's.
        seq.delete();
        for (int i = 0; i < 25; i++) seq.push_back(2'd0);
        run("t1", '0, 0, 25, 0, 1'b0, -1, -1, 1'b0);
        check_t1_const("t1");

        // ACGT guide with base 7 flipped.
        for (int k = 0; k < GL; k++) g_acgt[2*k +: 2] = 2'(k % 4);
        seq.delete();
        for (int i = 0; i < 20; i++) seq.push_back(2'(i % 4) ^ ((i == 7) ? 2'd2 : 2'd0));
        run("t2a", g_acgt, 0, 20, 0, 1'b0, -1, -1, 1'b0);
        check("t2a const n", got_q.size(), 0);
        run("t2b", g_acgt, 1, 20, 0, 1'b0, -1, -1, 1'b0);
`ifndef OTS_PAM_CHECK_EN
        check("t2b const n", got_q.size(), 1);
        if (got_q.size() > 0) check("t2b const word", got_q[0], {MW'(1), PW'(0)});
`endif

        // Back-pressure on the hit stream.
        seq.delete();
        for (int i = 0; i < 25; i++) seq.push_back(2'd0);
        run("t3", '0, 0, 25, 1, 1'b0, -1, -1, 1'b1);
        check_t1_const("t3");

        // Short sequence, with a start pulse during the search.
        seq.delete();
        for (int i = 0; i < 5; i++) seq.push_back(2'($urandom_range(0, 3)));
        run("t4", '0, 3, 5, 0, 1'b0, 2, -1, 1'b0);
        check("t4 const n", got_q.size(), 0);

        // Zero-length search.
        seq.delete();
        run("len0", '0, 0, 0, 0, 1'b0, -1, -1, 1'b0);

        // Reset in the middle of a search, then a clean rerun.
        seq.delete();
        for (int i = 0; i < 25; i++) seq.push_back(2'd0);
        run("t5 abort", '0, 0, 25, 0, 1'b0, -1, 12, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_state("t5 reset");
        reset = 1'b0;
        run("t5 rerun", '0, 0, 25, 0, 1'b0, -1, -1, 1'b0);
        check_t1_const("t5 rerun");

`ifdef OTS_PAM_CHECK_EN
        seq.delete();
        for (int i = 0; i < 20; i++) seq.push_back(2'd0);
        seq.push_back(2'd0); seq.push_back(2'd2); seq.push_back(2'd2);
        for (int i = 0; i < 20; i++) seq.push_back(2'd0);
        seq.push_back(2'd0); seq.push_back(2'd2); seq.push_back(2'd0);
        run("t6", '0, 0, 46, 0, 1'b0, -1, -1, 1'b0);
        check("t6 const n", got_q.size(), 1);
        if (got_q.size() > 0) check("t6 const word", got_q[0], {MW'(0), PW'(0)});
`endif

        // Randomized streams biased towards the guide so hits occur.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < GL; k++) g_rand[2*k +: 2] = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 48);
            mm  = $urandom_range(0, 3);
            seq.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0) seq.push_back(2'($urandom_range(0, 3)));
                else if (i % 24 >= 21) seq.push_back(2'd2);
                else seq.push_back(g_rand[2*(i % GL) +: 2]);
            end
            run("rand", g_rand, mm, len, 2, 1'b1, -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
